// File: rtl/fifo_rr_push_arbiter.sv
// Round-robin write-port arbiter for a single FIFO with burst locking.
// A requester that wins the port keeps it until it pushes a beat flagged
// last. No beat is ever pushed while the FIFO reports full. Transfers are
// zero latency: a selected beat is written to the FIFO on the same edge.
module fifo_rr_push_arbiter #(
    parameter int n_req = 4,
    parameter int width = 5
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [n_req-1:0]           i_req_valid,
    input  logic [n_req-1:0]           i_req_last,
    input  logic [n_req*width-1:0]     i_req_data,
    output logic [n_req-1:0]           o_req_ready,
    input  logic                       i_fifo_full,
    output logic                       o_fifo_push,
    output logic [width-1:0]           o_fifo_write_data,
    output logic [$clog2(n_req)-1:0]   o_grant_id,
    output logic                       o_locked
);

    localparam int IDX_W = $clog2(n_req);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_prio;
    logic [IDX_W-1:0]   w_prio_next;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   w_owner_next;

    logic               w_sel_found;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_push;
    logic               w_sel_last;
    logic [width-1:0]   w_slices [n_req];

    // Explicit modulo so that non-power-of-two requester counts wrap correctly.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        return IDX_W'(sum % n_req);
    endfunction

    // Split the flat data bus into one word per requester.
    for (genvar gi = 0; gi < n_req; gi++) begin : g_slice
        assign w_slices[gi]    = i_req_data[gi*width +: width];
        assign o_req_ready[gi] = w_push && (w_sel_idx == IDX_W'(gi));
    end

    // Selection: owner only while locked, otherwise first valid from prio upward.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = (r_state == LOCKED) ? r_owner : r_prio;
        if (r_state == LOCKED) begin
            w_sel_found = i_req_valid[r_owner];
        end else begin
            for (int k = 0; k < n_req; k++) begin
                if (!w_sel_found && i_req_valid[wrap_add(r_prio, k)]) begin
                    w_sel_found = 1'b1;
                    w_sel_idx   = wrap_add(r_prio, k);
                end
            end
        end
    end

    // A push needs a selected beat and FIFO space; nothing moves during reset.
    assign w_push            = w_sel_found && !i_fifo_full && !i_rst;
    assign w_sel_last        = i_req_last[w_sel_idx];
    assign o_fifo_push       = w_push;
    assign o_fifo_write_data = (w_sel_found && !i_rst) ? w_slices[w_sel_idx] : '0;
    assign o_grant_id        = i_rst ? '0 : w_sel_idx;
    assign o_locked          = (r_state == LOCKED) && !i_rst;

    // Next-state: state, prio and owner only move when a beat actually transfers.
    always_comb begin
        w_state_next = r_state;
        w_prio_next  = r_prio;
        w_owner_next = r_owner;
        if (w_push) begin
            case (r_state)
                IDLE: begin
                    if (w_sel_last) begin
                        w_prio_next = wrap_add(w_sel_idx, 1);
                    end else begin
                        w_state_next = LOCKED;
                        w_owner_next = w_sel_idx;
                    end
                end
                LOCKED: begin
                    if (w_sel_last) begin
                        w_state_next = IDLE;
                        w_prio_next  = wrap_add(r_owner, 1);
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // State register; reset drops any lock and returns priority to requester 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_prio  <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_next;
            r_prio  <= w_prio_next;
            r_owner <= w_owner_next;
        end
    end

endmodule

// File: tb/tb_fifo_rr_push_arbiter.sv
// Directed bench for fifo_rr_push_arbiter: a per-cycle reference model plus
// literal expectations on the sequence of granted requesters.
module tb_fifo_rr_push_arbiter;

    localparam int N = 4;
    localparam int W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     valid;
    logic [N-1:0]     last;
    logic [N*W-1:0]   data;
    logic [N-1:0]     ready;
    logic             full;
    logic             push;
    logic [W-1:0]     wdata;
    logic [1:0]       gid;
    logic             lck;

    int checks = 0;
    int errors = 0;
    int cyc_num = 0;

    // Reference state: lock flag, rotating priority, burst owner.
    bit m_locked = 1'b0;
    int m_prio   = 0;
    int m_owner  = 0;
    int push_log[$];

    fifo_rr_push_arbiter #(.n_req(N), .width(W)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_req_valid       (valid),
        .i_req_last        (last),
        .i_req_data        (data),
        .o_req_ready       (ready),
        .i_fifo_full       (full),
        .o_fifo_push       (push),
        .o_fifo_write_data (wdata),
        .o_grant_id        (gid),
        .o_locked          (lck)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare outputs against the model mid-cycle, then advance the model
    // by what must happen at the coming rising edge.
    always @(negedge clk) begin
        bit found;
        int sel;
        int idx;
        bit e_push;
        if (rst) begin
            chk("rst_push", int'(push), 0);
            chk("rst_ready", int'(ready), 0);
            chk("rst_locked", int'(lck), 0);
            chk("rst_grant", int'(gid), 0);
            chk("rst_wdata", int'(wdata), 0);
            m_locked = 1'b0;
            m_prio   = 0;
            m_owner  = 0;
        end else begin
            found = 1'b0;
            sel   = m_locked ? m_owner : m_prio;
            if (m_locked) begin
                found = valid[m_owner];
            end else begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_prio + k) % N;
                    if (!found && valid[idx]) begin
                        found = 1'b1;
                        sel   = idx;
                    end
                end
            end
            e_push = found && !full;
            chk("push", int'(push), int'(e_push));
            chk("ready", int'(ready), e_push ? (1 << sel) : 0);
            chk("grant", int'(gid), sel);
            chk("locked", int'(lck), int'(m_locked));
            chk("wdata", int'(wdata), found ? int'(data[sel*W +: W]) : 0);
            chk("no_push_when_full", int'(push && full), 0);
            if (e_push) begin
                $display("push req=%0d data=%0d last=%0b", sel, data[sel*W +: W], last[sel]);
                push_log.push_back(sel);
                if (last[sel]) begin
                    m_locked = 1'b0;
                    m_prio   = (sel + 1) % N;
                end else begin
                    m_locked = 1'b1;
                    m_owner  = sel;
                end
            end
        end
    end

    // Drive one cycle of stimulus; data word of requester i = i*8 + cycle[2:0].
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] l, input logic f);
        valid = v;
        last  = l;
        full  = f;
        for (int i = 0; i < N; i++) data[i*W +: W] = W'(i * 8 + (cyc_num % 8));
        cyc_num++;
        @(posedge clk);
        #1;
    endtask

    // Compare the recorded grant sequence with a hand-written list.
    task automatic chk_log(input string name, input int exp[8], input int n);
        chk({name, "_count"}, push_log.size(), n);
        for (int i = 0; i < n && i < push_log.size(); i++) chk(name, push_log[i], exp[i]);
        push_log.delete();
    endtask

    initial begin
        rst   = 1'b1;
        valid = '0;
        last  = '0;
        full  = 1'b0;
        data  = '0;
        repeat (2) @(posedge clk);
        #1;
        valid = 4'b1111;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: everyone valid, single-beat bursts -> plain rotation
        repeat (8) step(4'b1111, 4'b1111, 1'b0);
        chk_log("t1_rotation", '{0, 1, 2, 3, 0, 1, 2, 3}, 8);

        // 2: move prio to 1, then req1 bursts 3 beats while req0/req2 wait
        step(4'b0001, 4'b0001, 1'b0);
        push_log.delete();
        step(4'b0111, 4'b0000, 1'b0);
        chk("t2_locked_after_beat1", int'(lck), 1);
        step(4'b0111, 4'b0000, 1'b0);
        chk("t2_locked_after_beat2", int'(lck), 1);
        step(4'b0111, 4'b0010, 1'b0);
        chk("t2_unlocked_after_beat3", int'(lck), 0);
        step(4'b0101, 4'b0101, 1'b0);
        chk_log("t2_burst", '{1, 1, 1, 2, 0, 0, 0, 0}, 4);

        // 3: req2 alone, FIFO full for two cycles
        step(4'b0100, 4'b0100, 1'b1);
        step(4'b0100, 4'b0100, 1'b1);
        chk_log("t3_blocked", '{0, 0, 0, 0, 0, 0, 0, 0}, 0);
        step(4'b0100, 4'b0100, 1'b0);
        chk_log("t3_after_full", '{2, 0, 0, 0, 0, 0, 0, 0}, 1);

        // 4: req3 single beat, then all valid -> wrap to 0
        step(4'b1111, 4'b1111, 1'b0);
        step(4'b1111, 4'b1111, 1'b0);
        chk_log("t4_wrap", '{3, 0, 0, 0, 0, 0, 0, 0}, 2);

        // 5: req0 locks, drops valid for two cycles while req1 waits
        step(4'b0001, 4'b0000, 1'b0);
        chk("t5_locked", int'(lck), 1);
        step(4'b0010, 4'b0010, 1'b0);
        step(4'b0010, 4'b0010, 1'b0);
        chk("t5_still_locked", int'(lck), 1);
        step(4'b0011, 4'b0000, 1'b0);
        step(4'b0011, 4'b0001, 1'b0);
        chk("t5_released", int'(lck), 0);
        step(4'b0011, 4'b0011, 1'b0);
        chk_log("t5_hold", '{0, 0, 0, 1, 0, 0, 0, 0}, 4);

        // 6: reset pulsed in the middle of a req2 burst
        step(4'b0100, 4'b0000, 1'b0);
        chk("t6_locked_before_rst", int'(lck), 1);
        rst   = 1'b1;
        valid = 4'b1111;
        #1;
        chk("t6_rst_locked", int'(lck), 0);
        chk("t6_rst_push", int'(push), 0);
        chk("t6_rst_ready", int'(ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(4'b1111, 4'b1111, 1'b0);
        chk_log("t6_after_rst", '{2, 0, 0, 0, 0, 0, 0, 0}, 2);

        repeat (2) step(4'b0000, 4'b0000, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
